// File: rtl/mac_pkg.sv
// Shared types, default widths and constant helpers for the signed MAC block.
// Pure declarations: no logic, no latency, no flow control.
// Helpers are evaluated at elaboration time only.
package mac_pkg;

    typedef enum logic [1:0] {
        MUL = 2'b00,
        ACC = 2'b01,
        SUB = 2'b10
    } mac_mode_e;

    localparam int A_WIDTH_DEF    = 20;
    localparam int B_WIDTH_DEF    = 18;
    localparam int PROD_WIDTH_DEF = A_WIDTH_DEF + B_WIDTH_DEF;
    localparam int ACC_WIDTH_DEF  = PROD_WIDTH_DEF + 10;

    // Signed limit of a w-bit field: neg=1 gives the most negative value,
    // neg=0 the most positive; the caller keeps the low w bits.
    function automatic logic [127:0] sat_limit(input logic neg, input int w);
        logic [127:0] msb;
        msb = 128'd1 << (w - 1);
        return neg ? msb : (msb - 128'd1);
    endfunction

    function automatic bit params_ok(input int a_w, input int b_w,
                                     input int acc_w, input int pipe);
        return (acc_w >= a_w + b_w) && (acc_w <= 127) &&
               (pipe >= 2) && (pipe <= 4);
    endfunction

endpackage

// File: rtl/mac_delay_line.sv
// Fixed-depth shift register, one stage per clock, synchronous active-low clear.
// Latency: DEPTH cycles (DEPTH >= 1).
// No backpressure: every stage advances on every clock.
module mac_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
        end else begin
            taps[0] <= d;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign q = taps[DEPTH-1];

endmodule

// File: rtl/mac_and_reflect_input_b_pipelined.sv
// Signed multiply / accumulate / subtract-accumulate with sticky overflow and B echo.
// Latency: exactly PIPE_STAGES cycles from sample to P in every mode.
// No backpressure: the pipeline advances every clock; valid_i=0 inserts a bubble.
module mac_and_reflect_input_b_pipelined
    import mac_pkg::*;
#(
    parameter int A_WIDTH     = A_WIDTH_DEF,
    parameter int B_WIDTH     = B_WIDTH_DEF,
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int PIPE_STAGES = 2,
    parameter int SATURATE    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_i,
    input  logic [1:0]           mode_i,
    input  logic                 clear_i,
    input  logic [A_WIDTH-1:0]   A,
    input  logic [B_WIDTH-1:0]   B,
    output logic [ACC_WIDTH-1:0] P,
    output logic [B_WIDTH-1:0]   DlyB_o,
    output logic                 valid_o,
    output logic                 ovf_o
);

    localparam int PROD_W = A_WIDTH + B_WIDTH;
    localparam int SB_W   = B_WIDTH + 4;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_limit(1'b0, ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_limit(1'b1, ACC_WIDTH));

    generate
        if (!params_ok(A_WIDTH, B_WIDTH, ACC_WIDTH, PIPE_STAGES)) begin : g_bad_params
            $error("mac_and_reflect_input_b_pipelined: illegal ACC_WIDTH or PIPE_STAGES");
        end
    endgenerate

    // Sideband layout: {B, mode, clear, valid}
    logic [A_WIDTH-1:0]       s1_a;
    logic [SB_W-1:0]          s1_sb;
    logic [SB_W-1:0]          sn_sb;
    logic signed [PROD_W-1:0] prod_s1;
    logic [PROD_W-1:0]        prod_n;

    mac_delay_line #(.WIDTH(A_WIDTH + SB_W), .DEPTH(1)) u_stage1 (
        .clk   (clk),
        .reset (reset),
        .d     ({A, B, mode_i, clear_i, valid_i}),
        .q     ({s1_a, s1_sb})
    );

    assign prod_s1 = $signed(PROD_W'($signed(s1_a))) *
                     $signed(PROD_W'($signed(s1_sb[SB_W-1 -: B_WIDTH])));

    generate
        if (PIPE_STAGES > 2) begin : g_mid
            mac_delay_line #(.WIDTH(PROD_W), .DEPTH(PIPE_STAGES - 2)) u_prod_dly (
                .clk   (clk),
                .reset (reset),
                .d     (prod_s1),
                .q     (prod_n)
            );
            mac_delay_line #(.WIDTH(SB_W), .DEPTH(PIPE_STAGES - 2)) u_sb_dly (
                .clk   (clk),
                .reset (reset),
                .d     (s1_sb),
                .q     (sn_sb)
            );
        end else begin : g_direct
            assign prod_n = prod_s1;
            assign sn_sb  = s1_sb;
        end
    endgenerate

    logic [B_WIDTH-1:0] sn_b;
    logic [1:0]         sn_mode;
    logic               sn_clear;
    logic               sn_valid;

    assign sn_b     = sn_sb[SB_W-1:4];
    assign sn_mode  = sn_sb[3:2];
    assign sn_clear = sn_sb[1];
    assign sn_valid = sn_sb[0];

    logic [ACC_WIDTH-1:0]    acc_q;
    logic [B_WIDTH-1:0]      dlyb_q;
    logic                    vld_q;
    logic                    ovf_q;
    logic signed [ACC_WIDTH:0] base_x;
    logic signed [ACC_WIDTH:0] prod_x;
    logic signed [ACC_WIDTH:0] sum_x;
    logic                    sum_ovf;
    logic [ACC_WIDTH-1:0]    res;

    // One guard bit above ACC_WIDTH: the sum always fits, so overflow is a
    // disagreement between the guard bit and the ACC_WIDTH sign bit.
    always_comb begin
        base_x = sn_clear ? '0 : {acc_q[ACC_WIDTH-1], acc_q};
        prod_x = {{(ACC_WIDTH + 1 - PROD_W){prod_n[PROD_W-1]}}, prod_n};
        case (mac_mode_e'(sn_mode))
            ACC:     sum_x = base_x + prod_x;
            SUB:     sum_x = base_x - prod_x;
            default: sum_x = prod_x;
        endcase
        sum_ovf = sum_x[ACC_WIDTH] ^ sum_x[ACC_WIDTH-1];
        res     = sum_x[ACC_WIDTH-1:0];
        if ((SATURATE != 0) && sum_ovf) begin
            res = sum_x[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q  <= '0;
            dlyb_q <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            vld_q <= sn_valid;
            if (sn_valid) begin
                acc_q  <= res;
                dlyb_q <= sn_b;
                ovf_q  <= (ovf_q & ~sn_clear) | sum_ovf;
            end else if (sn_clear) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end
        end
    end

    assign P       = acc_q;
    assign DlyB_o  = dlyb_q;
    assign valid_o = vld_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_mac_and_reflect_input_b_pipelined.sv
// Bench: three MAC configurations driven in parallel, checked against a queue-based model.
module tb_mac_and_reflect_input_b_pipelined;

    typedef struct {
        logic signed [63:0] p;
        logic signed [63:0] b;
        logic signed [63:0] v;
        logic signed [63:0] o;
    } exp_t;

    localparam int NPIPE [3] = '{2, 3, 4};
    localparam int ACCW  [3] = '{48, 38, 38};
    localparam int SATV  [3] = '{0, 1, 0};

    logic               clk;
    logic               reset;
    logic               valid_i;
    logic [1:0]         mode_i;
    logic               clear_i;
    logic signed [19:0] a_in;
    logic signed [17:0] b_in;

    logic signed [47:0] p0;
    logic signed [37:0] p1, p2;
    logic signed [17:0] b0, b1, b2;
    logic               v0, v1, v2, o0, o1, o2;

    mac_and_reflect_input_b_pipelined #(.A_WIDTH(20), .B_WIDTH(18), .ACC_WIDTH(48),
        .PIPE_STAGES(2), .SATURATE(0)) u_dut0 (
        .clk(clk), .reset(reset), .valid_i(valid_i), .mode_i(mode_i), .clear_i(clear_i),
        .A(a_in), .B(b_in), .P(p0), .DlyB_o(b0), .valid_o(v0), .ovf_o(o0));

    mac_and_reflect_input_b_pipelined #(.A_WIDTH(20), .B_WIDTH(18), .ACC_WIDTH(38),
        .PIPE_STAGES(3), .SATURATE(1)) u_dut1 (
        .clk(clk), .reset(reset), .valid_i(valid_i), .mode_i(mode_i), .clear_i(clear_i),
        .A(a_in), .B(b_in), .P(p1), .DlyB_o(b1), .valid_o(v1), .ovf_o(o1));

    mac_and_reflect_input_b_pipelined #(.A_WIDTH(20), .B_WIDTH(18), .ACC_WIDTH(38),
        .PIPE_STAGES(4), .SATURATE(0)) u_dut2 (
        .clk(clk), .reset(reset), .valid_i(valid_i), .mode_i(mode_i), .clear_i(clear_i),
        .A(a_in), .B(b_in), .P(p2), .DlyB_o(b2), .valid_o(v2), .ovf_o(o2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   nvec  = 0;
    int   nfail = 0;
    exp_t sbq [3][$];
    longint             macc [3];
    logic signed [17:0] mb   [3];
    logic               movf [3];

    task automatic cmp(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t observe(input int d);
        exp_t r;
        case (d)
            0:       r = '{64'(p0), 64'(b0), 64'(v0), 64'(o0)};
            1:       r = '{64'(p1), 64'(b1), 64'(v1), 64'(o1)};
            default: r = '{64'(p2), 64'(b2), 64'(v2), 64'(o2)};
        endcase
        return r;
    endfunction

    // Output-register state the sample will leave behind once it reaches the last stage.
    task automatic model_sample(input int d, input logic v, input logic [1:0] m,
                                input logic c, input logic signed [19:0] a,
                                input logic signed [17:0] b);
        longint prod, base, sum, maxv, minv;
        logic   o;
        if (v) begin
            prod = longint'(a) * longint'(b);
            base = c ? 64'sd0 : macc[d];
            case (m)
                2'b01:   sum = base + prod;
                2'b10:   sum = base - prod;
                default: sum = prod;
            endcase
            maxv = (64'sd1 <<< (ACCW[d] - 1)) - 64'sd1;
            minv = -maxv - 64'sd1;
            o = (sum > maxv) || (sum < minv);
            if (o && SATV[d] != 0) sum = (sum > maxv) ? maxv : minv;
            else                   sum = (sum <<< (64 - ACCW[d])) >>> (64 - ACCW[d]);
            macc[d] = sum;
            mb[d]   = b;
            movf[d] = (c ? 1'b0 : movf[d]) | o;
        end else if (c) begin
            macc[d] = 0;
            movf[d] = 1'b0;
        end
        sbq[d].push_back('{64'(macc[d]), 64'(mb[d]), 64'(v), 64'(movf[d])});
    endtask

    task automatic check_dut(input int d, input logic rst);
        exp_t e, ob;
        e = '{64'sd0, 64'sd0, 64'sd0, 64'sd0};
        if (rst && sbq[d].size() >= NPIPE[d]) e = sbq[d].pop_front();
        ob = observe(d);
        cmp($sformatf("dut%0d P", d),      ob.p, e.p);
        cmp($sformatf("dut%0d DlyB_o", d), ob.b, e.b);
        cmp($sformatf("dut%0d valid_o", d), ob.v, e.v);
        cmp($sformatf("dut%0d ovf_o", d),  ob.o, e.o);
    endtask

    task automatic step(input logic rst, input logic v, input logic [1:0] m,
                        input logic c, input logic signed [19:0] a,
                        input logic signed [17:0] b);
        @(negedge clk);
        reset = rst; valid_i = v; mode_i = m; clear_i = c; a_in = a; b_in = b;
        for (int d = 0; d < 3; d++) begin
            if (!rst) begin
                sbq[d].delete();
                macc[d] = 0; mb[d] = '0; movf[d] = 1'b0;
            end else begin
                model_sample(d, v, m, c, a, b);
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) check_dut(d, rst);
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'b00, 1'b0, 20'sd0, 18'sd0);
    endtask

    initial begin
        reset = 1'b0; valid_i = 1'b0; mode_i = 2'b00; clear_i = 1'b0;
        a_in = '0; b_in = '0;
        for (int d = 0; d < 3; d++) begin
            macc[d] = 0; mb[d] = '0; movf[d] = 1'b0;
        end

        repeat (3) step(1'b0, 1'b1, 2'b00, 1'b0, 20'sd7, 18'sd3);

        // Multiply mode; direct checks on the PIPE_STAGES=2 instance
        step(1'b1, 1'b1, 2'b00, 1'b0, 20'sd5, 18'sd2);
        step(1'b1, 1'b1, 2'b00, 1'b0, -20'sd3, 18'sd4);
        cmp("mul P first", 64'(p0), 64'sd10);
        cmp("mul DlyB first", 64'(b0), 64'sd2);
        step(1'b1, 1'b1, 2'b00, 1'b0, -20'sd524288, -18'sd131072);
        cmp("mul P second", 64'(p0), -64'sd12);
        bubbles(1);
        cmp("mul P extreme", 64'(p0), 64'sd68719476736);
        cmp("mul DlyB extreme", 64'(b0), -64'sd131072);
        bubbles(3);

        // Accumulate with a bubble, then subtract
        step(1'b1, 1'b1, 2'b01, 1'b1, 20'sd1, 18'sd1);
        step(1'b1, 1'b1, 2'b01, 1'b0, 20'sd2, 18'sd3);
        cmp("acc P 1", 64'(p0), 64'sd1);
        step(1'b1, 1'b0, 2'b01, 1'b0, 20'sd0, 18'sd0);
        cmp("acc P 7", 64'(p0), 64'sd7);
        step(1'b1, 1'b1, 2'b01, 1'b0, -20'sd4, 18'sd2);
        cmp("acc P hold", 64'(p0), 64'sd7);
        cmp("acc bubble valid", 64'(v0), 64'sd0);
        step(1'b1, 1'b1, 2'b10, 1'b0, 20'sd1, 18'sd1);
        cmp("acc P -1", 64'(p0), -64'sd1);
        bubbles(1);
        cmp("sub P -2", 64'(p0), -64'sd2);
        bubbles(3);

        // Overflow: saturating (dut1) and wrapping (dut2)
        step(1'b1, 1'b1, 2'b01, 1'b1, 20'sd524287, 18'sd131071);
        repeat (4) step(1'b1, 1'b1, 2'b01, 1'b0, 20'sd524287, 18'sd131071);
        step(1'b1, 1'b1, 2'b01, 1'b1, 20'sd2, 18'sd2);
        cmp("sat P clamp", 64'(p1), 64'sd137438953471);
        cmp("sat ovf set", 64'(o1), 64'sd1);
        cmp("wrap P", 64'(p2), -64'sd68721442813);
        cmp("wrap ovf set", 64'(o2), 64'sd1);
        bubbles(2);
        cmp("sat clear P", 64'(p1), 64'sd4);
        cmp("sat clear ovf", 64'(o1), 64'sd0);
        bubbles(2);
        repeat (3) step(1'b1, 1'b1, 2'b01, 1'b0, 20'sd524287, 18'sd131071);
        bubbles(4);
        cmp("wrap ovf sticky", 64'(o2), 64'sd1);
        step(1'b1, 1'b0, 2'b01, 1'b1, 20'sd0, 18'sd0);
        bubbles(4);
        cmp("clear idle P", 64'(p2), 64'sd0);
        cmp("clear idle ovf", 64'(o2), 64'sd0);

        // Random regression with occasional mid-stream resets
        for (int i = 0; i < 1000; i++) begin
            logic               r_rst, r_v, r_c;
            logic [1:0]         r_m;
            logic signed [19:0] r_a;
            logic signed [17:0] r_b;
            r_rst = ($urandom_range(0, 99) != 0);
            r_v   = ($urandom_range(0, 3) != 0);
            r_m   = 2'($urandom_range(0, 3));
            r_c   = ($urandom_range(0, 15) == 0);
            r_a   = ($urandom_range(0, 2) == 0) ?
                    (($urandom_range(0, 1) == 0) ? 20'sd524287 : -20'sd524288) : 20'($urandom);
            r_b   = ($urandom_range(0, 2) == 0) ?
                    (($urandom_range(0, 1) == 0) ? 18'sd131071 : -18'sd131072) : 18'($urandom);
            step(r_rst, r_v, r_m, r_c, r_a, r_b);
        end
        bubbles(5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/mac_and_reflect_input_b_pipelined.md
Name: mac_and_reflect_input_B_pipelined

Overview:
Parametrised signed multiply / multiply-accumulate DSP block with a configurable pipeline depth and a valid qualifier.
It extends the registered multiplier by adding accumulate and subtract-accumulate modes, a sticky overflow flag with optional saturation, and a delayed copy of B that stays aligned with P.
The block maps onto a hard DSP slice and is used in filter and correlator datapaths.

Parameters:
A_WIDTH, 20, signed width of operand A.
B_WIDTH, 18, signed width of operand B.
ACC_WIDTH, 48, signed width of P and of the accumulator. Must be >= A_WIDTH+B_WIDTH.
PIPE_STAGES, 2, total latency in cycles from input sample to P. Legal range 2..4.
SATURATE, 0, overflow handling: 1 = clamp to the ACC_WIDTH signed limits, 0 = two's-complement wrap.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
valid_i  input  1  A, B, mode_i and clear_i are sampled on this cycle
mode_i  input  2  operation select: 00 = P=A*B, 01 = acc+=A*B, 10 = acc-=A*B, 11 = reserved (treated as 00)
clear_i  input  1  zero the accumulator and the overflow flag; travels with its sample
A  input  A_WIDTH  signed multiplicand
B  input  B_WIDTH  signed multiplier
P  output  ACC_WIDTH  signed result
DlyB_o  output  B_WIDTH  B delayed by PIPE_STAGES cycles, aligned with P
valid_o  output  1  P and DlyB_o hold a new result
ovf_o  output  1  sticky overflow flag

Behaviour:
- Reset: clk and reset are the only clock and reset; reset is synchronous and active-low. While reset=0 at a rising edge, every pipeline register is cleared.
  - P=0, DlyB_o=0, valid_o=0, ovf_o=0, accumulator=0.
  - Reset asserted mid-operation discards all in-flight samples. The first output after release comes from the first valid_i sampled after release.
- Pipeline: no backpressure; every stage advances on every clock.
  - Stage 1 registers A, B, mode_i, clear_i and valid_i.
  - Stages 2..PIPE_STAGES-1 carry the full-width signed product A*B, which is A_WIDTH+B_WIDTH bits.
  - Stage PIPE_STAGES is the output/accumulator register.
  - Latency is exactly PIPE_STAGES cycles in every mode.
- Arithmetic:
  - The product is sign-extended to ACC_WIDTH+1 bits and the accumulation is computed at that width.
  - Overflow means the result falls outside [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - SATURATE=1: clamp to the limit in the direction of the overflow.
  - SATURATE=0: keep the low ACC_WIDTH bits.
  - Either way, ovf_o goes to 1 and stays there.
- Mode 00: P=product and the accumulator is loaded with the product. Mode 00 cannot overflow.
- Modes 01 and 10: the accumulator is updated with +product or -product, and P equals the new accumulator value.
- Bubbles: a sample with valid=0 reaching the last stage leaves P, DlyB_o and the accumulator unchanged, and valid_o=0 for that cycle.
- clear with valid=1 (simultaneous events):
  - The accumulator is treated as 0 before the update, so P = +product (modes 00/01) or -product (mode 10).
  - ovf_o is cleared, then re-set if this same update overflows.
- clear with valid=0: the accumulator, P and ovf_o become 0; DlyB_o holds; valid_o=0.
- valid_o is valid_i delayed by PIPE_STAGES cycles. DlyB_o is updated only when valid_o=1.

Decomposition:
- Package mac_pkg holds:
  - mac_mode_e enum (MUL=2'b00, ACC=2'b01, SUB=2'b10);
  - localparam PROD_WIDTH = A_WIDTH+B_WIDTH;
  - a signed saturation helper function;
  - elaboration checks on ACC_WIDTH and PIPE_STAGES.
- One sub-module, mac_delay_line: a parametrised width/depth shift register with synchronous active-low reset. It is instantiated for the B/valid/mode/clear sideband and for the product stages.

Test Plan:
- Reset: drive A=7, B=3, valid_i=1 with reset=0 for 3 cycles -> P=0, DlyB_o=0, valid_o=0, ovf_o=0. After release, the first valid_o arrives exactly PIPE_STAGES cycles after the first valid_i.
- Multiply mode: PIPE_STAGES=2, mode=00; inputs A=5,B=2 then A=-3,B=4 then A=-524288,B=-131072 on consecutive cycles -> at cycles 2, 3, 4: P=10, -12, 68719476736. DlyB_o = 2, 4, -131072. valid_o=1 on each.
- Accumulate with bubbles: clear_i=1 on the first sample; mode=01 for A=1,B=1, then A=2,B=3, a valid_i=0 bubble, then A=-4,B=2 -> P sequence 1, 7, (hold 7, valid_o=0), -1. Then mode=10 with A=1,B=1 -> P=-2.
- Overflow, SATURATE=1, ACC_WIDTH=38: repeatedly accumulate A=524287, B=131071 -> P clamps at 137438953471 and ovf_o=1. A following clear_i=1 with valid_i=1, A=2, B=2 -> P=4 and ovf_o=0.
- Overflow wrap, SATURATE=0, same stimulus -> P = low 38 bits of the true sum and ovf_o=1 sticky. A clear with valid_i=0 -> P=0 and ovf_o=0.
- Random regression: 1000 samples with random valid, mode and clear, for PIPE_STAGES=2,3,4 -> P, DlyB_o, valid_o and ovf_o match the reference model every cycle. Include reset=0 pulses mid-stream.
